// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with occupancy count, almost-full flag, overflow/underflow
// pulses and push+pop replace-top. Define LIFO_STACK_PEEK_EN to add an indexed peek port.
module lifo_stack_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       PUSH,
  input  logic                       POP,
  input  logic [WIDTH-1:0]           DATA_IN,
  output logic [WIDTH-1:0]           DATA_OUT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       ALMOST_FULL,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
`ifdef LIFO_STACK_PEEK_EN
  input  logic [$clog2(DEPTH)-1:0]   PEEK_IDX,
  output logic [WIDTH-1:0]           PEEK_DATA,
  output logic                       PEEK_VALID,
`endif
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic             overflow_reg;
  logic             underflow_reg;

  logic             empty;
  logic             full;
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    below_idx;
  logic             mem_we;
  logic [PW-1:0]    mem_waddr;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  // Indices are only used when the matching occupancy condition holds, so truncation is safe.
  assign wr_idx    = PW'(count_reg);
  assign top_idx   = PW'(count_reg - CW'(1));
  assign below_idx = PW'(count_reg - CW'(2));

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    if (PUSH && POP) begin
      mem_we    = 1'b1;
      mem_waddr = empty ? '0 : top_idx;
    end else if (PUSH && !full) begin
      mem_we    = 1'b1;
      mem_waddr = wr_idx;
    end
  end

  // Storage carries no reset; a reset cycle suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && mem_we) begin
      mem[mem_waddr] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_reg     <= '0;
      data_out_reg  <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      if (PUSH && POP) begin
        // Replace-top; on an empty stack the push still lands but the pop is flagged.
        data_out_reg <= DATA_IN;
        if (empty) begin
          count_reg     <= CW'(1);
          underflow_reg <= 1'b1;
        end
      end else if (PUSH) begin
        if (full) begin
          overflow_reg <= 1'b1;
        end else begin
          count_reg    <= count_reg + CW'(1);
          data_out_reg <= DATA_IN;
        end
      end else if (POP) begin
        if (empty) begin
          underflow_reg <= 1'b1;
        end else begin
          count_reg    <= count_reg - CW'(1);
          data_out_reg <= (count_reg == CW'(1)) ? '0 : mem[below_idx];
        end
      end
    end
  end

  assign COUNT       = count_reg;
  assign DATA_OUT    = data_out_reg;
  assign EMPTY       = empty;
  assign FULL        = full;
  assign ALMOST_FULL = (count_reg >= CW'(AF_LEVEL));
  assign OVERFLOW    = overflow_reg;
  assign UNDERFLOW   = underflow_reg;

`ifdef LIFO_STACK_PEEK_EN
  logic [PW-1:0] peek_addr;

  // Index 0 is the top entry, counting downward into the stack.
  assign peek_addr  = PW'(count_reg - CW'(1) - CW'(PEEK_IDX));
  assign PEEK_VALID = (CW'(PEEK_IDX) < count_reg);
  assign PEEK_DATA  = PEEK_VALID ? mem[peek_addr] : '0;
`endif

endmodule
